// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: a lone request wins, a tie goes to the port not granted last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // Bit index equals port id (0 = IF, 1 = D).
  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == PORT_D) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one access at a time,
// sequenced IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP with a one-cycle rvalid pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              last_gnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic [1:0]        pick;
  logic [1:0]        gnt_vec;
  logic              last_cycle;

  rr_pick2 u_pick (
    .req      ({d_req, if_req}),
    .last_gnt (last_gnt_q),
    .gnt      (pick)
  );

  // Grants are only offered from IDLE and never while reset is held.
  assign gnt_vec    = (state_q == IDLE && !reset) ? pick : 2'b00;
  assign last_cycle = (cnt_q == CNT_W'(MEM_LATENCY - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_vec != 2'b00) state_d = ACCESS;
      ACCESS:  if (last_cycle) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_gnt_q <= PORT_IF;
      cnt_q      <= '0;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (gnt_vec != 2'b00) begin
      port_q     <= gnt_vec[PORT_D];
      last_gnt_q <= gnt_vec[PORT_D];
      cnt_q      <= '0;
      if (gnt_vec[PORT_D]) begin
        addr_q  <= d_addr;
        we_q    <= d_we;
        wdata_q <= d_wdata;
      end else begin
        addr_q  <= if_addr;
        we_q    <= 1'b0;
      end
    end else if (state_q == ACCESS) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_cycle && !we_q) begin
        if (port_q == PORT_D) begin
          d_rdata_q <= mem_rdata;
        end else begin
          if_rdata_q <= mem_rdata[31:0];
        end
      end
    end
  end

  // Decoded from state so an asynchronous reset removes the strobe at once.
  assign mem_wr    = (state_q == ACCESS) && (cnt_q == '0) && we_q && (port_q == PORT_D);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_gnt    = gnt_vec[PORT_IF];
  assign d_gnt     = gnt_vec[PORT_D];
  assign if_rvalid = (state_q == RESP) && (port_q == PORT_IF);
  assign d_rvalid  = (state_q == RESP) && (port_q == PORT_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
